// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall / bubble / flush scheduler for the 5-stage pipeline,
//               covering bus waits, load-use, multi-cycle mul/div, redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_busy,
    input  logic        mem_busy,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_md_start,
    input  logic        ex_md_is_div,
    input  logic        ex_br_taken,
    input  logic [63:0] ex_br_target,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        bubble_e,
    output logic        bubble_m,
    output logic        bubble_w,
    output logic        flush_fd,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        md_busy
);

    localparam logic [1:0] c_st_run = 2'd0;
    localparam logic [1:0] c_st_md  = 2'd1;
    localparam logic [1:0] c_st_mem = 2'd2;

    localparam logic [6:0] c_mul_m1 = 7'(MUL_LAT - 1);
    localparam logic [6:0] c_div_m1 = 7'(DIV_LAT - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_ret_state;
    logic [6:0]  r_md_cnt;
    logic        r_pend;
    logic [63:0] r_tgt;

    logic [1:0]  w_state_nxt;
    logic [1:0]  w_ret_nxt;
    logic [6:0]  w_md_cnt_nxt;
    logic [1:0]  w_eff_state;
    logic [6:0]  w_lat_m1;
    logic        w_md_entry;
    logic        w_md_release;
    logic        w_md_stall;
    logic        w_load_use;
    logic        w_br;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_run;
            r_ret_state <= c_st_run;
            r_md_cnt    <= 7'd0;
            r_pend      <= 1'b0;
            r_tgt       <= 64'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret_state <= w_ret_nxt;
            r_md_cnt    <= w_md_cnt_nxt;
            if (w_br) begin
                r_pend <= if_busy;
                r_tgt  <= ex_br_target;
            end else if (r_pend && !if_busy) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Once the data bus releases, MEM_WAIT behaves exactly like the state it
    // interrupted, so a bus wait costs no extra cycle beyond its own length.
    always_comb begin
        w_eff_state  = (r_state == c_st_mem) ? r_ret_state : r_state;
        w_lat_m1     = ex_md_is_div ? c_div_m1 : c_mul_m1;
        w_md_entry   = (w_eff_state == c_st_run) && ex_md_start && (w_lat_m1 != 7'd0);
        w_md_release = (w_eff_state == c_st_md) && (r_md_cnt <= 7'd1);
        w_md_stall   = w_md_entry || ((w_eff_state == c_st_md) && !w_md_release);
        w_load_use   = ex_is_load && (ex_rd != 5'd0) &&
                       ((ex_rd == dec_rs1) || (ex_rd == dec_rs2));
        w_br         = ex_br_taken && !mem_busy && !w_md_stall;
    end

    always_comb begin
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        stall_e        = 1'b0;
        stall_m        = 1'b0;
        bubble_e       = 1'b0;
        bubble_m       = 1'b0;
        bubble_w       = 1'b0;
        flush_fd       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        md_busy        = 1'b0;
        w_state_nxt    = w_eff_state;
        w_ret_nxt      = r_ret_state;
        w_md_cnt_nxt   = r_md_cnt;

        if (mem_busy) begin
            stall_f     = 1'b1;
            stall_d     = 1'b1;
            stall_e     = 1'b1;
            stall_m     = 1'b1;
            bubble_w    = 1'b1;
            w_state_nxt = c_st_mem;
            w_ret_nxt   = w_eff_state;
            md_busy     = (w_eff_state == c_st_md);
        end else if (w_md_stall) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            bubble_m = 1'b1;
            md_busy  = 1'b1;
            if (w_md_entry) begin
                w_state_nxt  = c_st_md;
                w_md_cnt_nxt = w_lat_m1;
            end else begin
                w_md_cnt_nxt = 7'(r_md_cnt - 7'd1);
            end
        end else begin
            if (w_md_release) begin
                md_busy      = 1'b1;
                w_state_nxt  = c_st_run;
                w_md_cnt_nxt = 7'd0;
            end
            // A redirect squashes D anyway, so it overrides a load-use hold.
            if (w_br) begin
                flush_fd = 1'b1;
                bubble_e = 1'b1;
                stall_f  = if_busy;
            end else if (w_load_use || if_busy) begin
                stall_f  = 1'b1;
                stall_d  = 1'b1;
                bubble_e = 1'b1;
            end
        end

        if (w_br) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_br_target;
        end else if (r_pend) begin
            redirect_valid = 1'b1;
            redirect_pc    = r_tgt;
            flush_fd       = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed scoreboard bench for pipe_hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam logic [9:0] c_sf = 10'b10_0000_0000;
    localparam logic [9:0] c_sd = 10'b01_0000_0000;
    localparam logic [9:0] c_se = 10'b00_1000_0000;
    localparam logic [9:0] c_sm = 10'b00_0100_0000;
    localparam logic [9:0] c_be = 10'b00_0010_0000;
    localparam logic [9:0] c_bm = 10'b00_0001_0000;
    localparam logic [9:0] c_bw = 10'b00_0000_1000;
    localparam logic [9:0] c_ff = 10'b00_0000_0100;
    localparam logic [9:0] c_rv = 10'b00_0000_0010;
    localparam logic [9:0] c_mb = 10'b00_0000_0001;
    localparam logic [63:0] c_tgt  = 64'h0000_0000_8000_0040;
    localparam logic [63:0] c_tgt2 = 64'h0000_0000_0000_1230;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_busy;
    logic        mem_busy;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_md_start;
    logic        ex_md_is_div;
    logic        ex_br_taken;
    logic [63:0] ex_br_target;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        bubble_e, bubble_m, bubble_w;
    logic        flush_fd, redirect_valid, md_busy;
    logic [63:0] redirect_pc;

    logic [73:0] exp_q[$];
    string       nm_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [73:0] mon_exp;
    logic [73:0] mon_act;
    string       mon_nm;

    pipe_hazard_ctrl #(.MUL_LAT(2), .DIV_LAT(64)) dut (
        .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .bubble_e(bubble_e), .bubble_m(bubble_m), .bubble_w(bubble_w),
        .flush_fd(flush_fd), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [73:0] mk(input logic [9:0] f, input logic [63:0] pc);
        return {pc, f};
    endfunction

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = nm_q.pop_front();
            mon_act = {redirect_pc, stall_f, stall_d, stall_e, stall_m, bubble_e,
                       bubble_m, bubble_w, flush_fd, redirect_valid, md_busy};
            n_tests++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: got flags=%b pc=%h, expected flags=%b pc=%h",
                         mon_nm, mon_act[9:0], mon_act[73:10], mon_exp[9:0], mon_exp[73:10]);
            end
        end
    end

    task automatic clear_in();
        reset = 1'b0; if_busy = 1'b0; mem_busy = 1'b0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; ex_is_load = 1'b0; ex_rd = 5'd0;
        ex_md_start = 1'b0; ex_md_is_div = 1'b0; ex_br_taken = 1'b0;
        ex_br_target = 64'd0;
    endtask

    // Inputs are set by the caller before step; they are cleared afterwards.
    task automatic step(input string nm, input logic [73:0] e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        clear_in();
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("reset_state", mk(10'd0, 64'd0));

        // Load-use
        ex_is_load = 1'b1; ex_rd = 5'd5; dec_rs1 = 5'd5;
        step("loaduse_rs1", mk(c_sf | c_sd | c_be, 64'd0));
        step("loaduse_after", mk(10'd0, 64'd0));
        ex_is_load = 1'b1; ex_rd = 5'd0; dec_rs1 = 5'd0;
        step("loaduse_x0", mk(10'd0, 64'd0));
        ex_is_load = 1'b1; ex_rd = 5'd7; dec_rs2 = 5'd7; dec_rs1 = 5'd3;
        step("loaduse_rs2", mk(c_sf | c_sd | c_be, 64'd0));
        ex_is_load = 1'b0; ex_rd = 5'd7; dec_rs1 = 5'd7;
        step("nonload_match", mk(10'd0, 64'd0));

        // Multiply, latency 2
        ex_md_start = 1'b1;
        step("mul_entry", mk(c_sf | c_sd | c_se | c_bm | c_mb, 64'd0));
        step("mul_release", mk(c_mb, 64'd0));
        step("mul_done", mk(10'd0, 64'd0));

        // Divide, latency 64: 63 stall cycles then a release cycle
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        step("div_entry", mk(c_sf | c_sd | c_se | c_bm | c_mb, 64'd0));
        for (int i = 1; i <= 62; i++)
            step($sformatf("div_stall_%0d", i), mk(c_sf | c_sd | c_se | c_bm | c_mb, 64'd0));
        step("div_release", mk(c_mb, 64'd0));
        step("div_done", mk(10'd0, 64'd0));

        // Divide interrupted by a 3-cycle data bus wait at cycle 5
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        step("divm_entry", mk(c_sf | c_sd | c_se | c_bm | c_mb, 64'd0));
        for (int i = 1; i <= 65; i++) begin
            if (i >= 5 && i <= 7) begin
                mem_busy = 1'b1;
                step($sformatf("divm_mem_%0d", i),
                     mk(c_sf | c_sd | c_se | c_sm | c_bw | c_mb, 64'd0));
            end else begin
                step($sformatf("divm_stall_%0d", i), mk(c_sf | c_sd | c_se | c_bm | c_mb, 64'd0));
            end
        end
        step("divm_release", mk(c_mb, 64'd0));
        step("divm_done", mk(10'd0, 64'd0));

        // Reset in the middle of a divide
        ex_md_start = 1'b1; ex_md_is_div = 1'b1;
        step("divr_entry", mk(c_sf | c_sd | c_se | c_bm | c_mb, 64'd0));
        for (int i = 1; i <= 9; i++)
            step($sformatf("divr_stall_%0d", i), mk(c_sf | c_sd | c_se | c_bm | c_mb, 64'd0));
        reset = 1'b1;
        step("divr_reset_cycle", mk(c_sf | c_sd | c_se | c_bm | c_mb, 64'd0));
        step("divr_after_reset", mk(10'd0, 64'd0));
        step("divr_idle", mk(10'd0, 64'd0));

        // Redirect while the instruction bus is busy for 4 cycles
        ex_br_taken = 1'b1; ex_br_target = c_tgt; if_busy = 1'b1;
        step("br_busy_issue", mk(c_sf | c_be | c_ff | c_rv, c_tgt));
        for (int i = 1; i <= 3; i++) begin
            if_busy = 1'b1;
            step($sformatf("br_pending_%0d", i), mk(c_sf | c_sd | c_be | c_ff | c_rv, c_tgt));
        end
        step("br_pending_release", mk(c_ff | c_rv, c_tgt));
        step("br_pending_clear", mk(10'd0, 64'd0));

        // Plain redirect, and redirect beating a load-use hazard
        ex_br_taken = 1'b1; ex_br_target = c_tgt2;
        step("br_plain", mk(c_be | c_ff | c_rv, c_tgt2));
        step("br_plain_after", mk(10'd0, 64'd0));
        ex_br_taken = 1'b1; ex_br_target = c_tgt;
        ex_is_load = 1'b1; ex_rd = 5'd9; dec_rs1 = 5'd9;
        step("br_vs_loaduse", mk(c_be | c_ff | c_rv, c_tgt));

        // Branch held during a multiply: only honoured on the release cycle
        ex_md_start = 1'b1; ex_br_taken = 1'b1; ex_br_target = c_tgt2;
        step("br_md_held", mk(c_sf | c_sd | c_se | c_bm | c_mb, 64'd0));
        ex_br_taken = 1'b1; ex_br_target = c_tgt2;
        step("br_md_release", mk(c_mb | c_be | c_ff | c_rv, c_tgt2));
        step("br_md_after", mk(10'd0, 64'd0));

        // Instruction bus busy alone, then data bus busy from RUN
        if_busy = 1'b1;
        step("if_busy_only", mk(c_sf | c_sd | c_be, 64'd0));
        mem_busy = 1'b1; if_busy = 1'b1;
        step("mem_busy_run", mk(c_sf | c_sd | c_se | c_sm | c_bw, 64'd0));
        step("mem_wait_exit", mk(10'd0, 64'd0));
        step("final_idle", mk(10'd0, 64'd0));

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
